// File: rtl/add_multicycle.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock through a registered
// carry, with a start/busy/done handshake and registered sum/carry/overflow outputs.
module add_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op_a_q, op_b_q, work_q, work_d, sum_q;
  logic             carry_q, cout_q, ovf_q, busy_q, done_q;
  logic [IW-1:0]    idx_q;

  int               slice_base;
  logic [CHUNK-1:0] slice_a, slice_b, slice_s;
  logic             slice_c, last_slice;

  // One CHUNK-wide adder shared by every slice; work_d is the result image with
  // the current slice merged in, so the final slice can go straight to sum_q.
  always_comb begin
    slice_base = CHUNK * int'(idx_q);
    slice_a    = op_a_q[slice_base +: CHUNK];
    slice_b    = op_b_q[slice_base +: CHUNK];
    {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};
    work_d     = work_q;
    work_d[slice_base +: CHUNK] = slice_s;
    last_slice = (idx_q == IW'(N - 1));
  end

  // NOTE: every register in this block uses <=, so all reads within the same
  // edge see pre-edge values; the working registers are reset too, because an
  // aborted operation must leave no stale slices behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_a_q  <= a;
            op_b_q  <= sub ? ~b : b;
            carry_q <= sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          work_q  <= work_d;
          carry_q <= slice_c;
          idx_q   <= idx_q + IW'(1);
          if (last_slice) begin
            sum_q   <= work_d;
            cout_q  <= slice_c;
            // Signed overflow: operands agree in sign but the result does not.
            ovf_q   <= (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                       (slice_s[CHUNK-1] != op_a_q[WIDTH-1]);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_add_multicycle.sv
// Scoreboard bench for add_multicycle: three instances (CHUNK 8, 32, 4) share stimulus,
// expected results are queued at issue time and popped when done pulses.
module tb_add_multicycle;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  int          sel = 0;

  logic        start8, start32, start4;
  logic [31:0] sum8, sum32, sum4;
  logic        c8, c32, c4, v8, v32, v4;
  logic        busy8, busy32, busy4, done8, done32, done4;

  logic [31:0] sum_w;
  logic        c_w, v_w, busy_w, done_w;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] prev_sum = '0;

  always #5 clk = ~clk;

  assign start8  = start && (sel == 0);
  assign start32 = start && (sel == 1);
  assign start4  = start && (sel == 2);

  add_multicycle #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub), .a(a), .b(b),
    .sum(sum8), .carry_out(c8), .overflow(v8), .busy(busy8), .done(done8));

  add_multicycle #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .sub(sub), .a(a), .b(b),
    .sum(sum32), .carry_out(c32), .overflow(v32), .busy(busy32), .done(done32));

  add_multicycle #(.WIDTH(32), .CHUNK(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub), .a(a), .b(b),
    .sum(sum4), .carry_out(c4), .overflow(v4), .busy(busy4), .done(done4));

  always_comb begin
    sum_w = sum8; c_w = c8; v_w = v8; busy_w = busy8; done_w = done8;
    if (sel == 1) begin
      sum_w = sum32; c_w = c32; v_w = v32; busy_w = busy32; done_w = done32;
    end else if (sel == 2) begin
      sum_w = sum4; c_w = c4; v_w = v4; busy_w = busy4; done_w = done4;
    end
  end

  function automatic int exp_lat();
    return (sel == 1) ? 1 : (sel == 2) ? 8 : 4;
  endfunction

  function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib, input logic isub);
    exp_t        e;
    logic [31:0] bb;
    logic [32:0] full;
    bb   = isub ? ~ib : ib;
    full = {1'b0, ia} + {1'b0, bb} + {32'd0, isub};
    e.s  = full[31:0];
    e.c  = full[32];
    e.v  = (ia[31] == bb[31]) && (full[31] != ia[31]);
    return e;
  endfunction

  // Called at a negedge; start is seen at the next rising edge (E0).
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                       input exp_t e);
    a = ia; b = ib; sub = isub; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy_w !== 1'b1 || done_w !== 1'b0) begin
      n_err++;
      $display("FAIL accept: busy=%b done=%b, want busy=1 done=0", busy_w, done_w);
    end
  endtask

  // Waits for done, checking latency, busy width and output hold; poke >= 0 re-asserts
  // start with junk operands in that RUN cycle.
  task automatic collect(input string name, input int poke);
    int   lat = 0;
    int   busy_cnt = 0;
    bit   held = 1'b1;
    exp_t e;
    while (done_w !== 1'b1 && lat < 64) begin
      if (busy_w === 1'b1) busy_cnt++;
      if (sum_w !== prev_sum) held = 1'b0;
      if (lat == poke) begin
        a = 32'h1234_5678; b = 32'h0BAD_F00D; sub = ~sub; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    n_vec++;
    if (done_w !== 1'b1) begin
      n_err++;
      $display("FAIL %s timeout: no done within %0d cycles", name, lat);
      return;
    end
    n_vec++;
    if (lat != exp_lat()) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat());
    end
    n_vec++;
    if (busy_cnt != exp_lat() || busy_w !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy: high %0d cycles, busy at done=%b, want %0d and 0",
               name, busy_cnt, busy_w, exp_lat());
    end
    n_vec++;
    if (!held) begin
      n_err++;
      $display("FAIL %s hold: sum changed before done, want %h held", name, prev_sum);
    end
    n_vec++;
    if ({sum_w, c_w, v_w} !== {e.s, e.c, e.v}) begin
      n_err++;
      $display("FAIL %s result: got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
               name, sum_w, c_w, v_w, e.s, e.c, e.v);
    end
    prev_sum = e.s;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({sum_w, c_w, v_w, busy_w, done_w} !== '0) begin
      n_err++;
      $display("FAIL reset: got sum=%h c=%b v=%b busy=%b done=%b want all 0",
               sum_w, c_w, v_w, busy_w, done_w);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({sum_w, c_w, v_w, busy_w, done_w} !== '0) begin
        n_err++;
        $display("FAIL idle%0d: got sum=%h c=%b v=%b busy=%b done=%b want all 0",
                 i, sum_w, c_w, v_w, busy_w, done_w);
      end
    end
  endtask

  task automatic test_carry_chain();
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, '{32'h0000_0100, 1'b0, 1'b0});
    collect("carry_ff", -1);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0});
    collect("carry_wrap", -1);
  endtask

  task automatic test_overflow();
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1});
    collect("ovf_pos", -1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h0000_0000, 1'b1, 1'b1});
    collect("ovf_neg", -1);
  endtask

  task automatic test_subtract();
    issue(32'd5, 32'd7, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0});
    collect("sub_borrow", -1);
    issue(32'h8000_0000, 32'd1, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1});
    collect("sub_ovf", -1);
    issue(32'd9, 32'd9, 1'b1, '{32'h0000_0000, 1'b1, 1'b0});
    collect("sub_zero", -1);
  endtask

  task automatic test_handshake();
    issue(32'h1111_1111, 32'h2222_2222, 1'b0, '{32'h3333_3333, 1'b0, 1'b0});
    collect("hs_ignore", 1);
    // Still in the done cycle: this start must be accepted.
    issue(32'h4000_0000, 32'h4000_0000, 1'b0, '{32'h8000_0000, 1'b0, 1'b1});
    collect("hs_donecycle", -1);
  endtask

  task automatic test_reset_midop();
    bit saw_done = 1'b0;
    issue(32'h0101_0101, 32'h0202_0202, 1'b0, '{32'h0303_0303, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b1;
    #1;
    void'(sb.pop_back());
    n_vec++;
    if ({sum_w, c_w, v_w, busy_w, done_w} !== '0) begin
      n_err++;
      $display("FAIL midop_reset: got sum=%h c=%b v=%b busy=%b done=%b want all 0",
               sum_w, c_w, v_w, busy_w, done_w);
    end
    @(negedge clk);
    reset = 1'b0;
    prev_sum = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_w !== 1'b0 || busy_w !== 1'b0) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done) begin
      n_err++;
      $display("FAIL midop_quiet: got done/busy activity after abort, want none");
    end
    issue(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, '{32'hDEAD_BEEF, 1'b0, 1'b0});
    collect("midop_next", -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic        rs;
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 32'h0000_0000; rb = 32'h8000_0000; rs = 1'b1; end
      issue(ra, rb, rs, model(ra, rb, rs));
      collect($sformatf("b2b%0d", i), -1);
    end
  endtask

  task automatic test_widths();
    sel = 1;
    prev_sum = '0;
    test_carry_chain();
    sel = 2;
    prev_sum = '0;
    test_carry_chain();
    sel = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_carry_chain();
    test_overflow();
    test_subtract();
    test_handshake();
    test_reset_midop();
    test_back_to_back();
    test_widths();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/add_multicycle.md
# add_multicycle

Parametrised multi-cycle adder/subtractor for the MIPS datapath. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between slices through a registered carry, so a narrow adder can serve a wide datapath. A start/busy/done handshake controls it. It generalises the single-bit half adder with a carry-in chain, a subtract mode, signed overflow detection and sequential slice processing.

## Interface

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; N = WIDTH/CHUNK slices, N ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request; sampled only when idle.
- sub  input  1  0 = a+b, 1 = a−b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- sum  output  WIDTH  registered result.
- carry_out  output  1  carry out of MSB; in sub mode 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse, result valid.

## Operation

- **States:** IDLE and RUN.
- **Reset:**
  - state = IDLE.
  - sum, carry_out, overflow, busy and done are all 0.
  - Working registers and slice index are 0.
- **Accepting a request (IDLE, start=1):**
  - Latch opA = a and opB = sub ? ~b : b.
  - Set carry = sub and slice index i = 0.
  - Go to RUN; busy = 1.
- **IDLE with start=0:** hold all state. done is 0 except in the single pulse cycle.
- **RUN, each cycle:**
  - Compute {c, s} = opA[i] + opB[i] + carry, where opA[i] and opB[i] are CHUNK-bit slices and s goes to work[i].
  - Update carry = c and i = i+1.
- **Last slice (i = N−1):**
  - sum ← work with slice N−1 merged in; carry_out ← c.
  - overflow ← (opA[MSB] == opB[MSB]) && (s[MSB] != opA[MSB]).
  - done ← 1, busy ← 0, state ← IDLE.
- **Output stability:** sum, carry_out and overflow change only at the done edge. They hold their values until the next completion and are never partially updated.
- **start while busy:** ignored, not queued. a, b and sub may change freely during RUN.
- **Reset mid-operation:** aborts the operation, produces no done pulse and clears all outputs to 0.
- **Width rules:**
  - Addition is modulo 2^WIDTH.
  - Subtraction is a + ~b + 1.
  - Operands are treated as unsigned for carry_out and as two's-complement for overflow.

## Timing

- **Start edge:** start is sampled at edge E0; busy is high after E0.
- **Slice edges:** slices are processed at edges E1…EN.
- **Completion:** at EN, sum, carry_out and overflow update, done is high for the cycle after EN, and busy falls at EN.
- **Latency:** N cycles from start edge to the done cycle. For WIDTH=32, CHUNK=8: 4. For CHUNK=WIDTH: 1.
- **Throughput:** one operation per N+1 cycles when start is held high. A start asserted during the done cycle is accepted, because state is IDLE during that cycle.
- **done:** exactly one cycle wide per completed operation.
- **Reset:** asynchronous assertion takes effect without a clock edge. Deassertion is synchronous to clk by system design.

## Test plan

All scenarios use WIDTH=32, CHUNK=8 unless noted.

1. **Reset:** assert reset for 2 cycles, then release.
   - sum=0, carry_out=0, overflow=0, busy=0, done=0.
   - Idle with start=0 keeps them at 0.
2. **Carry chain:** add 0x000000FF + 0x00000001.
   - Result sum=0x00000100, carry_out=0, overflow=0.
   - done high exactly 4 cycles after the start edge; busy high for 4 cycles.
   - Repeat 0xFFFFFFFF + 0x00000001, expecting sum=0, carry_out=1, overflow=0.
3. **Signed overflow:**
   - 0x7FFFFFFF + 0x00000001 gives sum=0x80000000, overflow=1, carry_out=0.
   - 0x80000000 + 0x80000000 gives sum=0, overflow=1, carry_out=1.
4. **Subtract:**
   - 5 − 7 gives sum=0xFFFFFFFE, carry_out=0 (borrow), overflow=0.
   - 0x80000000 − 1 gives sum=0x7FFFFFFF, carry_out=1, overflow=1.
   - 9 − 9 gives sum=0, carry_out=1, overflow=0.
5. **Handshake:**
   - Re-assert start with different operands in RUN cycle 2: it is ignored, and the first result is unchanged.
   - Assert start during the done cycle: the second operation is accepted, and its done arrives 4 cycles later.
   - sum holds the first result until the second done.
6. **Reset mid-op:** assert reset in the 2nd RUN cycle.
   - No done pulse; all outputs are 0 immediately.
   - Next start completes normally.
   - Rerun scenario 2 with CHUNK=32 (latency 1) and CHUNK=4 (latency 8).
